// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } md_state_e;

    // Codes written to $rstatus when the multdiv unit raises an exception.
    localparam int unsigned RSTATUS_MULT_EXC    = 4;
    localparam int unsigned RSTATUS_DIV_EXC     = 5;
    localparam int unsigned RSTATUS_REG_DEFAULT = 30;

endpackage

// File: rtl/multdiv_watchdog.sv
// Cycle counter that flags when an enabled count reaches TIMEOUT-1.
module multdiv_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired_c = enable && (count_q == CNT_W'(TIMEOUT - 1));

    // Next count: clear wins, otherwise count up while enabled and not at the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_controller.sv
// Sequencer for the shared multiply/divide unit: accept, start, stall, write back.
module multdiv_controller
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned REG_BITS    = 5,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned RSTATUS_REG = RSTATUS_REG_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                op_valid,
    input  logic                op_is_div,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic [REG_BITS-1:0] op_rd,
    input  logic                flush,
    input  logic [WIDTH-1:0]    md_result,
    input  logic                md_ready,
    input  logic                md_exception,
    output logic                md_ctrl_mult,
    output logic                md_ctrl_div,
    output logic [WIDTH-1:0]    md_a,
    output logic [WIDTH-1:0]    md_b,
    output logic                stall,
    output logic                wb_valid,
    output logic [REG_BITS-1:0] wb_rd,
    output logic [WIDTH-1:0]    wb_data,
    output logic                busy,
    output logic                timeout_err
);

    md_state_e           state_q, state_d;
    logic                is_div_q, is_div_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [REG_BITS-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                exc_q, exc_d;
    logic                timeout_err_q, timeout_err_d;

    logic accept;
    logic wd_enable;
    logic wd_expired;

    assign accept    = (state_q == ST_IDLE) && op_valid && !flush;
    assign wd_enable = (state_q == ST_BUSY) || (state_q == ST_DRAIN);

    multdiv_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == ST_START),
        .enable   (wd_enable),
        .expired_c(wd_expired)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            is_div_q      <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            rd_q          <= '0;
            result_q      <= '0;
            exc_q         <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_div_q      <= is_div_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rd_q          <= rd_d;
            result_q      <= result_d;
            exc_q         <= exc_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next state; a result arriving alongside a flush still gets written back.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (md_ready) begin
                    state_d = ST_DONE;
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (md_ready || wd_expired) state_d = ST_IDLE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand latch on accept, result capture in BUSY, sticky watchdog flag.
    always_comb begin
        is_div_d      = is_div_q;
        a_d           = a_q;
        b_d           = b_q;
        rd_d          = rd_q;
        result_d      = result_q;
        exc_d         = exc_q;
        timeout_err_d = timeout_err_q;
        if (accept) begin
            is_div_d = op_is_div;
            a_d      = op_a;
            b_d      = op_b;
            rd_d     = op_rd;
        end
        if ((state_q == ST_BUSY) && md_ready) begin
            result_d = md_result;
            exc_d    = md_exception;
        end
        if (wd_expired && !md_ready) begin
            timeout_err_d = 1'b1;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        busy         = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE:  stall = op_valid && !flush;
            ST_START: begin
                stall        = 1'b1;
                md_ctrl_div  = is_div_q;
                md_ctrl_mult = !is_div_q;
            end
            ST_BUSY:  stall = 1'b1;
            ST_DRAIN: stall = 1'b0;
            ST_DONE: begin
                if (exc_q) begin
                    wb_valid = 1'b1;
                    wb_rd    = REG_BITS'(RSTATUS_REG);
                    wb_data  = is_div_q ? WIDTH'(RSTATUS_DIV_EXC) : WIDTH'(RSTATUS_MULT_EXC);
                end else begin
                    wb_valid = (rd_q != '0);
                    wb_rd    = rd_q;
                    wb_data  = result_q;
                end
            end
            default: stall = 1'b0;
        endcase
    end

    assign md_a        = a_q;
    assign md_b        = b_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/multdiv_controller.md
# multdiv_controller

Sequencer for the shared multiply/divide unit in the execute stage. It accepts one mult/div instruction at a time and latches its operands and destination. It issues a single-cycle start pulse to the multdiv unit and stalls the pipeline until the result returns. It then produces one writeback beat, redirected to `$rstatus` on a multdiv exception, and handles flush and watchdog-timeout cases.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- REG_BITS, 5, register index width
- TIMEOUT, 64, max cycles in BUSY before abort
- RSTATUS_REG, 30, exception destination register

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  X-stage mult/div instruction present
- op_is_div  in  1  1 = div, 0 = mult
- op_a, op_b  in  WIDTH  operands
- op_rd  in  REG_BITS  destination register
- flush  in  1  squash the in-flight op (branch/jump)
- md_result  in  WIDTH  multdiv unit result
- md_ready  in  1  multdiv unit result valid, one-cycle pulse
- md_exception  in  1  multdiv unit overflow / divide-by-zero, valid with md_ready
- md_ctrl_mult, md_ctrl_div  out  1  start pulses to the multdiv unit
- md_a, md_b  out  WIDTH  registered operands to the multdiv unit
- stall  out  1  freeze F/D/X
- wb_valid  out  1  writeback beat
- wb_rd  out  REG_BITS  writeback register
- wb_data  out  WIDTH  writeback data
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, START, BUSY, DRAIN, DONE.
- **IDLE:**
  - op_valid=1 and flush=0 → latch op_a/op_b/op_rd/op_is_div, go to START.
  - stall = op_valid & ~flush (combinational).
- **START:**
  - Exactly one cycle of md_ctrl_div (if is_div) or md_ctrl_mult (otherwise).
  - md_a/md_b already hold the latched operands.
  - Counter cleared. Go to BUSY. stall=1.
- **BUSY:**
  - stall=1; counter increments each cycle.
  - md_ready → capture md_result/md_exception, go to DONE.
  - flush and no md_ready → go to DRAIN.
  - Counter reaches TIMEOUT-1 without md_ready → set timeout_err, go to IDLE, no writeback.
- **DRAIN:**
  - stall=0; wait for md_ready (or timeout) and discard it; go to IDLE.
  - op_valid is not accepted in DRAIN.
- **DONE:**
  - stall=0; wb_valid=1 for one cycle; go to IDLE.
  - No exception: wb_rd=latched rd, wb_data=captured result.
  - Exception: wb_rd=RSTATUS_REG, wb_data=4 (mult) or 5 (div).
  - wb_valid is suppressed when rd=0 and there is no exception.
- md_ready is ignored in IDLE and START.
- md_ready and flush in the same BUSY cycle: md_ready wins, so writeback occurs. The flushing instruction is younger than the mult/div.
- md_a/md_b hold their value from acceptance until the next acceptance.

## Timing
- Reset values:
  - state=IDLE; counter=0; timeout_err=0.
  - md_ctrl_*=0, md_a=md_b=0.
  - stall=0 with op_valid=0; wb_valid=0, wb_rd=0, wb_data=0; busy=0.
- Reset in any state (including BUSY/DRAIN) → IDLE next edge. A later md_ready is ignored.
- Latency: op accepted at edge N; start pulse high during cycle N+1; md_ready in cycle N+1+k gives wb_valid in cycle N+2+k.
- The pipeline advances in the DONE cycle, so back-to-back mult/div costs at least one IDLE cycle between ops.
- timeout_err clears only on reset.

## Structure
- Package `multdiv_pkg`:
  - state enum (IDLE/START/BUSY/DRAIN/DONE)
  - RSTATUS_MULT_EXC=4, RSTATUS_DIV_EXC=5
  - default RSTATUS_REG
- Sub-module `multdiv_watchdog`: a cycle counter with clear/enable/expired, parameterised by TIMEOUT.

## Test plan
- mult 7 × −3, rd=5, md_ready 32 cycles after start with result −21 → one start pulse on md_ctrl_mult; stall high 34 cycles; wb_valid with rd=5, data=0xFFFFFFEB.
- div 100 / 0, rd=8, md_ready+md_exception → wb_rd=30, wb_data=5; mult overflow case → wb_data=4.
- flush 3 cycles after start, md_ready 20 cycles later → stall drops the cycle after the flush; no wb_valid; busy until md_ready; then IDLE.
- md_ready never arrives, TIMEOUT=64 → timeout_err=1 after 64 BUSY cycles; stall=0; no wb; stays set until reset.
- reset asserted mid-BUSY, then md_ready pulses → all outputs return to reset values; no wb_valid.
- Two back-to-back mults (rd=3, rd=4; op_valid held) → two separate start pulses; writebacks in order; rd=0 op produces no wb_valid.
